i2c_txn_sequencer: RTL and testbench

Parametrised I2C transaction sequencer sitting between the display/peripheral controllers and the byte-level I2C engine. It turns one request (7-bit address, optional command byte, 0..MAX_LEN data bytes) into a START/ADDR/CMD/DATA/STOP instruction sequence. Write bytes arrive over a valid/ready stream, and optional read transactions return bytes on a pulsed output. It adds an engine watchdog and bounded automatic retry of the address/command phase on NACK.

---
 rtl/i2c_txn_sequencer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_sequencer.sv
// ============================================================================
// i2c_txn_sequencer
//
// Purpose:
//   Turns one request into the instruction sequence that the byte-level I2C
//   engine executes. A request carries a 7-bit address, an optional command
//   byte and 0..MAX_LEN data bytes. The sequence is START / ADDR / CMD /
//   DATA... / STOP. Write bytes are pulled from a valid/ready stream. Read
//   bytes, when the read path is built, are returned on a one-cycle pulse.
//   Every engine operation is guarded by a watchdog. A failure in the
//   address/command phase is retried a bounded number of times.
//
// Build option:
//   I2C_SEQ_READ_EN - when defined, the read path is built. This covers rw,
//                     the repeated START, i2c_nack, rd_data and rd_valid.
//                     When undefined, every request is a write and the read
//                     outputs are tied to 0.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   start             request strobe, sampled only while idle
//   rw                0 = write, 1 = read (read build only)
//   address, cmd      target address and command byte
//   use_cmd           send cmd after the address
//   len               data byte count, clamped to MAX_LEN
//   wr_data/valid     write byte stream in; wr_ready out
//   rd_data/rd_valid  read byte out, one-cycle pulse per byte
//   busy, done, error transaction status (error is sticky until next start)
//   instruction       engine op: 0 START, 1 STOP, 2 READ, 3 WRITE
//   enable_i2c        engine op request
//   byteToSend        engine write byte
//   i2c_nack          master NACK for the current READ op
//   i2c_rx_byte       engine read byte
//   i2c_error         engine error (NACK or bus fault)
//   i2c_complete      engine idle/complete
// ============================================================================
module i2c_txn_sequencer #(
    parameter int MAX_LEN     = 16,
    parameter int LEN_W       = $clog2(MAX_LEN + 1),
    parameter int RETRIES     = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             rw,
    input  logic [6:0]       address,
    input  logic [7:0]       cmd,
    input  logic             use_cmd,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       instruction,
    output logic             enable_i2c,
    output logic [7:0]       byteToSend,
    output logic             i2c_nack,
    input  logic [7:0]       i2c_rx_byte,
    input  logic             i2c_error,
    input  logic             i2c_complete
);

`ifdef I2C_SEQ_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    localparam int RET_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_WRITE = 2'd3;

    // S_NEXT is the cycle between two engine ops. S_DATA waits for a write byte.
    typedef enum logic [1:0] {
        S_IDLE,
        S_NEXT,
        S_DATA,
        S_WAIT
    } state_t;

    // Phase of the transaction. While in S_WAIT this is the op in flight.
    // While in S_NEXT it is the op about to be issued.
    typedef enum logic [2:0] {
        P_START,
        P_ADDR_W,
        P_CMD,
        P_RSTART,
        P_ADDR_R,
        P_DATA,
        P_READ,
        P_STOP
    } phase_t;

    // The reason a STOP is being issued decides what happens after it.
    typedef enum logic [1:0] {
        STOP_NORMAL,
        STOP_RETRY,
        STOP_FAIL
    } stop_t;

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    stop_t            stop_mode_q, stop_mode_d;
    logic [6:0]       addr_q, addr_d;
    logic [7:0]       cmd_q, cmd_d;
    logic             use_cmd_q, use_cmd_d;
    logic             rd_q, rd_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [RET_W-1:0] retry_q, retry_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             started_q, started_d;
    logic             progress_q, progress_d;
    logic [1:0]       instr_q, instr_d;
    logic             enable_q, enable_d;
    logic [7:0]       byte_q, byte_d;
    logic             nack_q, nack_d;
    logic             wr_ready_q, wr_ready_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             issue;
    phase_t           issue_phase;
    logic             timeout;
    logic             last_byte;
    logic [LEN_W-1:0] len_clamped;

    assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    assign timeout     = (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign last_byte   = ((cnt_q + LEN_W'(1)) == len_q);

    // Next-state logic. Each op is set up in one place, after the state case.
    // The op is issued when some branch raises `issue`.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        stop_mode_d = stop_mode_q;
        addr_d      = addr_q;
        cmd_d       = cmd_q;
        use_cmd_d   = use_cmd_q;
        rd_d        = rd_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        wd_d        = wd_q;
        started_d   = started_q;
        progress_d  = progress_q;
        instr_d     = instr_q;
        enable_d    = enable_q;
        byte_d      = byte_q;
        nack_d      = nack_q;
        wr_ready_d  = wr_ready_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        issue       = 1'b0;
        issue_phase = P_START;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = address;
                    cmd_d       = cmd;
                    use_cmd_d   = use_cmd;
                    len_d       = len_clamped;
                    // A read with no bytes degenerates into a write probe.
                    rd_d        = READ_EN && rw && (len_clamped != '0);
                    cnt_d       = '0;
                    retry_d     = RET_W'(RETRIES);
                    progress_d  = 1'b0;
                    stop_mode_d = STOP_NORMAL;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    issue       = 1'b1;
                    issue_phase = P_START;
                end
            end

            S_NEXT: begin
                if (phase_q == P_DATA) begin
                    wr_ready_d = 1'b1;
                    state_d    = S_DATA;
                end else begin
                    issue       = 1'b1;
                    issue_phase = phase_q;
                end
            end

            S_DATA: begin
                if (wr_valid && wr_ready_q) begin
                    wr_ready_d  = 1'b0;
                    byte_d      = wr_data;
                    progress_d  = 1'b1;
                    issue       = 1'b1;
                    issue_phase = P_DATA;
                end
            end

            S_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                if (!i2c_complete) begin
                    started_d = 1'b1;
                end

                if (i2c_error || timeout) begin
                    enable_d = 1'b0;
                    if (phase_q == P_STOP) begin
                        // A failing STOP of a retry does not matter. Any other
                        // failing STOP ends the transaction in error.
                        if (stop_mode_q == STOP_RETRY) begin
                            stop_mode_d = STOP_NORMAL;
                            phase_d     = P_START;
                            state_d     = S_NEXT;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            error_d = 1'b1;
                        end
                    end else begin
                        // Retry only while no data has been transferred.
                        // Once data moves, repeating it could duplicate side effects.
                        phase_d = P_STOP;
                        state_d = S_NEXT;
                        if (!progress_q && (retry_q != '0)) begin
                            stop_mode_d = STOP_RETRY;
                            retry_d     = retry_q - RET_W'(1);
                        end else begin
                            stop_mode_d = STOP_FAIL;
                        end
                    end
                end else if (started_q && i2c_complete) begin
                    enable_d = 1'b0;
                    state_d  = S_NEXT;
                    case (phase_q)
                        P_START: begin
                            phase_d = (rd_q && !use_cmd_q) ? P_ADDR_R : P_ADDR_W;
                        end
                        P_RSTART: begin
                            phase_d = P_ADDR_R;
                        end
                        P_ADDR_W: begin
                            if (use_cmd_q) begin
                                phase_d = P_CMD;
                            end else begin
                                phase_d = (len_q == '0) ? P_STOP : P_DATA;
                            end
                        end
                        P_CMD: begin
                            if (rd_q) begin
                                phase_d = P_RSTART;
                            end else begin
                                phase_d = (len_q == '0) ? P_STOP : P_DATA;
                            end
                        end
                        P_ADDR_R: begin
                            phase_d = P_READ;
                        end
                        P_DATA: begin
                            cnt_d   = cnt_q + LEN_W'(1);
                            phase_d = last_byte ? P_STOP : P_DATA;
                        end
                        P_READ: begin
                            rd_data_d  = i2c_rx_byte;
                            rd_valid_d = 1'b1;
                            progress_d = 1'b1;
                            cnt_d      = cnt_q + LEN_W'(1);
                            phase_d    = last_byte ? P_STOP : P_READ;
                        end
                        P_STOP: begin
                            if (stop_mode_q == STOP_RETRY) begin
                                stop_mode_d = STOP_NORMAL;
                                phase_d     = P_START;
                            end else begin
                                state_d = S_IDLE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                error_d = (stop_mode_q == STOP_FAIL);
                            end
                        end
                        default: begin
                            phase_d = P_STOP;
                        end
                    endcase
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Set up the engine op. The watchdog and the start-seen flag restart for every op.
        if (issue) begin
            enable_d  = 1'b1;
            wd_d      = '0;
            started_d = 1'b0;
            nack_d    = 1'b0;
            phase_d   = issue_phase;
            state_d   = S_WAIT;
            case (issue_phase)
                P_START, P_RSTART: begin
                    instr_d = OP_START;
                end
                P_ADDR_W: begin
                    instr_d = OP_WRITE;
                    byte_d  = {addr_q, 1'b0};
                end
                P_CMD: begin
                    instr_d = OP_WRITE;
                    byte_d  = cmd_q;
                end
                P_ADDR_R: begin
                    instr_d = OP_WRITE;
                    byte_d  = {addr_q, 1'b1};
                end
                P_DATA: begin
                    instr_d = OP_WRITE;
                end
                P_READ: begin
                    instr_d = OP_READ;
                    nack_d  = (cnt_q == (len_q - LEN_W'(1)));
                end
                default: begin
                    instr_d = OP_STOP;
                end
            endcase
        end
    end

    // All state and every output are registered. Reset leaves the bus to the engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= P_START;
            stop_mode_q <= STOP_NORMAL;
            addr_q      <= '0;
            cmd_q       <= '0;
            use_cmd_q   <= 1'b0;
            rd_q        <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            retry_q     <= '0;
            wd_q        <= '0;
            started_q   <= 1'b0;
            progress_q  <= 1'b0;
            instr_q     <= 2'd0;
            enable_q    <= 1'b0;
            byte_q      <= '0;
            nack_q      <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            stop_mode_q <= stop_mode_d;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            use_cmd_q   <= use_cmd_d;
            rd_q        <= rd_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            wd_q        <= wd_d;
            started_q   <= started_d;
            progress_q  <= progress_d;
            instr_q     <= instr_d;
            enable_q    <= enable_d;
            byte_q      <= byte_d;
            nack_q      <= nack_d;
            wr_ready_q  <= wr_ready_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign instruction = instr_q;
    assign enable_i2c  = enable_q;
    assign byteToSend  = byte_q;

`ifdef I2C_SEQ_READ_EN
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign i2c_nack = nack_q;
`else
    assign rd_data  = 8'h00;
    assign rd_valid = 1'b0;
    assign i2c_nack = 1'b0;

    logic unused_read_path;
    assign unused_read_path = ^{rd_data_q, rd_valid_q, nack_q};
`endif

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// ============================================================================
// tb_i2c_txn_sequencer
//
// Self-checking bench for i2c_txn_sequencer using a scoreboard.
//
// Each test pushes the expected engine ops, read bytes and done/error results
// into queues. A behavioural engine model checks every op the DUT issues
// against the op queue. The engine can NACK an op on request, or hang so the
// watchdog fires. Separate monitors pop and compare rd_valid and done.
//
// DUT build: MAX_LEN=4, RETRIES=2, TIMEOUT_CYC=100.
// ============================================================================
module tb_i2c_txn_sequencer;

    localparam int MAX_LEN     = 4;
    localparam int LEN_W       = $clog2(MAX_LEN + 1);
    localparam int RETRIES     = 2;
    localparam int TIMEOUT_CYC = 100;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_WRITE = 2'd3;

    typedef struct packed {
        logic [1:0] instr;
        logic [7:0] data;
        logic       nack;
        logic       err;
        logic [7:0] rx;
    } op_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             rw;
    logic [6:0]       address;
    logic [7:0]       cmd;
    logic             use_cmd;
    logic [LEN_W-1:0] len;
    logic [7:0]       wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       instruction;
    logic             enable_i2c;
    logic [7:0]       byteToSend;
    logic             i2c_nack;
    logic [7:0]       i2c_rx_byte;
    logic             i2c_error;
    logic             i2c_complete;

    op_t        exp_ops[$];
    logic [7:0] exp_rd[$];
    logic       exp_done[$];
    logic [7:0] wr_q[$];

    int  tests_run    = 0;
    int  tests_failed = 0;
    int  done_cnt     = 0;
    int  rd_cnt       = 0;
    int  wr_acc       = 0;
    int  wr_ready_cnt = 0;
    logic eng_hang    = 1'b0;

    i2c_txn_sequencer #(
        .MAX_LEN    (MAX_LEN),
        .LEN_W      (LEN_W),
        .RETRIES    (RETRIES),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rw          (rw),
        .address     (address),
        .cmd         (cmd),
        .use_cmd     (use_cmd),
        .len         (len),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .instruction (instruction),
        .enable_i2c  (enable_i2c),
        .byteToSend  (byteToSend),
        .i2c_nack    (i2c_nack),
        .i2c_rx_byte (i2c_rx_byte),
        .i2c_error   (i2c_error),
        .i2c_complete(i2c_complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] allOutputs();
        return {7'd0, wr_ready, rd_data, rd_valid, busy, done, error,
                instruction, enable_i2c, byteToSend, i2c_nack};
    endfunction

    task automatic pushOp(input logic [1:0] instr, input logic [7:0] data,
                          input logic nack, input logic err, input logic [7:0] rx);
        op_t o;
        o.instr = instr;
        o.data  = data;
        o.nack  = nack;
        o.err   = err;
        o.rx    = rx;
        exp_ops.push_back(o);
    endtask

    // Pop the expected op and compare it with what the DUT presents.
    // The byte is compared only for WRITE ops.
    task automatic checkOp(output op_t cur);
        logic [7:0] act_b;
        logic [7:0] exp_b;
        if (exp_ops.size() == 0) begin
            cur = '0;
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL engine op: unexpected instr %0d byte 0x%0h, expected none",
                     instruction, byteToSend);
        end else begin
            cur   = exp_ops.pop_front();
            act_b = (instruction == OP_WRITE) ? byteToSend : 8'h00;
            exp_b = (cur.instr == OP_WRITE) ? cur.data : 8'h00;
            checkOutput("engine op {instr,byte,nack}",
                        {21'd0, instruction, act_b, i2c_nack},
                        {21'd0, cur.instr, exp_b, cur.nack});
        end
    endtask

    task automatic applyStimulus(input logic [6:0] a, input logic [7:0] c, input logic uc,
                                 input logic r, input logic [LEN_W-1:0] l);
        @(negedge clk);
        address = a;
        cmd     = c;
        use_cmd = uc;
        rw      = r;
        len     = l;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic waitDone(input string name, input int bound);
        int target;
        int n;
        target = done_cnt + 1;
        n = 0;
        while (done_cnt < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (done_cnt < target) begin
            tests_failed++;
            $display("[TB] FAIL %s done timeout: got no done within %0d cycles, expected done", name, bound);
        end
        repeat (2) @(negedge clk);
        checkOutput({name, " ops left"}, exp_ops.size(), 0);
        checkOutput({name, " done left"}, exp_done.size(), 0);
    endtask

    // Engine model. It accepts each op on the rising edge of enable_i2c and
    // drops complete for one cycle. It then completes, with an error if the
    // expected op asks for one. In hang mode it never completes.
    initial begin : engine
        op_t  cur;
        logic prev_en;
        prev_en      = 1'b0;
        i2c_complete = 1'b1;
        i2c_error    = 1'b0;
        i2c_rx_byte  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!eng_hang && !enable_i2c) i2c_complete = 1'b1;
            if (rst_n && enable_i2c && !prev_en) begin
                prev_en = 1'b1;
                checkOp(cur);
                i2c_complete = 1'b0;
                if (!eng_hang) begin
                    @(posedge clk);
                    #1;
                    i2c_rx_byte  = cur.rx;
                    i2c_error    = cur.err;
                    i2c_complete = 1'b1;
                    @(posedge clk);
                    #1;
                    i2c_error = 1'b0;
                    prev_en   = enable_i2c;
                end
            end else begin
                prev_en = enable_i2c;
            end
        end
    end

    // Write-byte source. A handshake seen at the falling edge takes effect on the next rising edge.
    initial begin : feeder
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (wr_valid && wr_ready) begin
                @(posedge clk);
                #1;
                if (wr_q.size() > 0) void'(wr_q.pop_front());
                wr_acc++;
            end else begin
                wr_valid = (wr_q.size() > 0);
                wr_data  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
            end
        end
    end

    // Monitor for read bytes, done pulses and wr_ready activity.
    initial begin : monitor
        logic [7:0] eb;
        logic       ee;
        forever begin
            @(negedge clk);
            if (wr_ready) wr_ready_cnt++;
            if (rd_valid) begin
                rd_cnt++;
                if (exp_rd.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL rd_valid: unexpected byte 0x%0h, expected none", rd_data);
                end else begin
                    eb = exp_rd.pop_front();
                    checkOutput("rd_data", rd_data, eb);
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_done.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL done: unexpected pulse (error %0d), expected none", error);
                end else begin
                    ee = exp_done.pop_front();
                    checkOutput("done error", error, ee);
                    checkOutput("busy at done", busy, 0);
                end
            end
        end
    end

    initial begin : global_guard
        #500000;
        $display("[TB] FAIL global time limit reached: got still running, expected finished");
        $fatal(1);
    end

    initial begin : stimulus
        int en_cycles;
        rst_n   = 1'b0;
        start   = 1'b0;
        rw      = 1'b0;
        address = 7'h00;
        cmd     = 8'h00;
        use_cmd = 1'b0;
        len     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset outputs", allOutputs(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0x3C, cmd 0x00, three data bytes
        wr_q = '{8'hAE, 8'h20, 8'h10};
        pushOp(OP_START, 8'h00, 0, 0, 0);
        pushOp(OP_WRITE, 8'h78, 0, 0, 0);
        pushOp(OP_WRITE, 8'h00, 0, 0, 0);
        pushOp(OP_WRITE, 8'hAE, 0, 0, 0);
        pushOp(OP_WRITE, 8'h20, 0, 0, 0);
        pushOp(OP_WRITE, 8'h10, 0, 0, 0);
        pushOp(OP_STOP,  8'h00, 0, 0, 0);
        exp_done.push_back(1'b0);
        applyStimulus(7'h3C, 8'h00, 1'b1, 1'b0, 3);
        checkOutput("busy after start", busy, 1);
        waitDone("write3", 200);

        // Probe 0x50, no command, no data
        wr_ready_cnt = 0;
        pushOp(OP_START, 8'h00, 0, 0, 0);
        pushOp(OP_WRITE, 8'hA0, 0, 0, 0);
        pushOp(OP_STOP,  8'h00, 0, 0, 0);
        exp_done.push_back(1'b0);
        applyStimulus(7'h50, 8'h00, 1'b0, 1'b0, 0);
        waitDone("probe", 200);
        checkOutput("probe wr_ready cycles", wr_ready_cnt, 0);

        // Address NACK twice, third attempt succeeds
        wr_q = '{8'h55};
        for (int i = 0; i < 2; i++) begin
            pushOp(OP_START, 8'h00, 0, 0, 0);
            pushOp(OP_WRITE, 8'h78, 0, 1, 0);
            pushOp(OP_STOP,  8'h00, 0, 0, 0);
        end
        pushOp(OP_START, 8'h00, 0, 0, 0);
        pushOp(OP_WRITE, 8'h78, 0, 0, 0);
        pushOp(OP_WRITE, 8'h55, 0, 0, 0);
        pushOp(OP_STOP,  8'h00, 0, 0, 0);
        exp_done.push_back(1'b0);
        applyStimulus(7'h3C, 8'h00, 1'b0, 1'b0, 1);
        waitDone("retry", 400);

        // NACK on the second data byte: no retry, error, two bytes consumed
        wr_acc = 0;
        wr_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        pushOp(OP_START, 8'h00, 0, 0, 0);
        pushOp(OP_WRITE, 8'h78, 0, 0, 0);
        pushOp(OP_WRITE, 8'h40, 0, 0, 0);
        pushOp(OP_WRITE, 8'hB1, 0, 0, 0);
        pushOp(OP_WRITE, 8'hB2, 0, 1, 0);
        pushOp(OP_STOP,  8'h00, 0, 0, 0);
        exp_done.push_back(1'b1);
        applyStimulus(7'h3C, 8'h40, 1'b1, 1'b0, 4);
        waitDone("data nack", 300);
        checkOutput("data nack bytes consumed", wr_acc, 2);
        wr_q.delete();
        repeat (3) @(negedge clk);
        checkOutput("error sticky", error, 1);

        // len 6 is clamped to MAX_LEN (4)
        wr_acc = 0;
        wr_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        pushOp(OP_START, 8'h00, 0, 0, 0);
        pushOp(OP_WRITE, 8'h42, 0, 0, 0);
        pushOp(OP_WRITE, 8'h01, 0, 0, 0);
        pushOp(OP_WRITE, 8'h02, 0, 0, 0);
        pushOp(OP_WRITE, 8'h03, 0, 0, 0);
        pushOp(OP_WRITE, 8'h04, 0, 0, 0);
        pushOp(OP_STOP,  8'h00, 0, 0, 0);
        exp_done.push_back(1'b0);
        applyStimulus(7'h21, 8'h00, 1'b0, 1'b0, 6);
        checkOutput("error cleared by start", error, 0);
        waitDone("clamp", 300);
        checkOutput("clamp bytes consumed", wr_acc, 4);
        wr_q.delete();
        repeat (2) @(negedge clk);

`ifdef I2C_SEQ_READ_EN
        // Read 0x68, cmd 0x3B, two bytes
        rd_cnt = 0;
        pushOp(OP_START, 8'h00, 0, 0, 0);
        pushOp(OP_WRITE, 8'hD0, 0, 0, 0);
        pushOp(OP_WRITE, 8'h3B, 0, 0, 0);
        pushOp(OP_START, 8'h00, 0, 0, 0);
        pushOp(OP_WRITE, 8'hD1, 0, 0, 0);
        pushOp(OP_READ,  8'h00, 0, 0, 8'h12);
        pushOp(OP_READ,  8'h00, 1, 0, 8'h34);
        pushOp(OP_STOP,  8'h00, 0, 0, 0);
        exp_rd.push_back(8'h12);
        exp_rd.push_back(8'h34);
        exp_done.push_back(1'b0);
        applyStimulus(7'h68, 8'h3B, 1'b1, 1'b1, 2);
        waitDone("read2", 300);
        checkOutput("read bytes returned", rd_cnt, 2);

        // A read with len 0 runs as a write probe
        pushOp(OP_START, 8'h00, 0, 0, 0);
        pushOp(OP_WRITE, 8'hD0, 0, 0, 0);
        pushOp(OP_WRITE, 8'h3B, 0, 0, 0);
        pushOp(OP_STOP,  8'h00, 0, 0, 0);
        exp_done.push_back(1'b0);
        applyStimulus(7'h68, 8'h3B, 1'b1, 1'b1, 0);
        waitDone("read len0", 200);
`else
        // Without the read path, rw=1 is an ordinary write
        rd_cnt = 0;
        wr_q = '{8'h77};
        pushOp(OP_START, 8'h00, 0, 0, 0);
        pushOp(OP_WRITE, 8'hD0, 0, 0, 0);
        pushOp(OP_WRITE, 8'h3B, 0, 0, 0);
        pushOp(OP_WRITE, 8'h77, 0, 0, 0);
        pushOp(OP_STOP,  8'h00, 0, 0, 0);
        exp_done.push_back(1'b0);
        applyStimulus(7'h68, 8'h3B, 1'b1, 1'b1, 1);
        waitDone("rw ignored", 300);
        checkOutput("rd_valid pulses without read path", rd_cnt, 0);
`endif

        // Engine hangs: each op times out after TIMEOUT_CYC cycles. Two retries, then an error.
        eng_hang = 1'b1;
        for (int i = 0; i < RETRIES + 1; i++) begin
            pushOp(OP_START, 8'h00, 0, 0, 0);
            pushOp(OP_STOP,  8'h00, 0, 0, 0);
        end
        exp_done.push_back(1'b1);
        applyStimulus(7'h3C, 8'h00, 1'b0, 1'b0, 0);
        en_cycles = 0;
        for (int i = 0; i < 3 * TIMEOUT_CYC; i++) begin
            if (!enable_i2c) break;
            en_cycles++;
            @(negedge clk);
        end
        checkOutput("enable high cycles before timeout", en_cycles, TIMEOUT_CYC);
        waitDone("timeout", 8 * TIMEOUT_CYC);

        // Reset while waiting on the engine returns every output to 0 at once
        pushOp(OP_START, 8'h00, 0, 0, 0);
        applyStimulus(7'h3C, 8'h00, 1'b0, 1'b0, 0);
        repeat (20) @(negedge clk);
        checkOutput("enable before mid-wait reset", enable_i2c, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("outputs after mid-wait reset", allOutputs(), 0);
        eng_hang = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle outputs after reset release", allOutputs(), 0);
        checkOutput("ops left after reset", exp_ops.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
